ram_burst_ctrl: RTL and testbench

Sequencer that sits directly upstream of the 1024x10 RAM and owns its write_enable/address/data_in pins.
- Accepts burst commands of 1..1024 words at a start address.
- Write bursts: streams words from a valid/ready producer into RAM.
- Read bursts: streams RAM words out to a valid/ready consumer.
- Used for program load and memory dump on the 10-bit processor.

---
 rtl/ram_burst_ctrl.sv | 150 +++++++++++++++
 tb/tb_ram_burst_ctrl.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_burst_ctrl.sv
// ram_burst_ctrl: burst sequencer in front of the 1024x10 single-port RAM.
// Write bursts move words from a valid/ready producer into the RAM, read
// bursts move RAM words out to a valid/ready consumer.
// Optional build macro RAMCTL_CHECKSUM_EN adds a running checksum output.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for a command; cmd_ready high
// WRITE | accepting write-stream words, one RAM write pulse per word
// READ  | capturing RAM words into the rd_data output register
// DRAIN | all words captured, waiting for the last rd_data handshake
module ram_burst_ctrl #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [ADDR_W:0]   cmd_len,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic              ram_write_enable,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data_in,
    input  logic [DATA_W-1:0] ram_data_out,
    output logic              busy,
    output logic              done
`ifdef RAMCTL_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] checksum
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    localparam logic [ADDR_W:0]   MAX_LEN  = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   LEN_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t            state;
    logic [ADDR_W:0]   remaining;

    logic cmd_accept;
    logic wr_accept;
    logic rd_capture;

    // Stream handshakes are decoded straight from the state so the ready
    // signals never lag a state change.
    assign cmd_ready  = (state == IDLE);
    assign busy       = (state != IDLE);
    assign wr_ready   = (state == WRITE);
    assign cmd_accept = (state == IDLE) && cmd_valid;
    assign wr_accept  = (state == WRITE) && wr_valid;
    assign rd_capture = (state == READ) && (!rd_valid || rd_ready);

    // Main sequencer: state, RAM pins, read-stream register and done pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= IDLE;
            remaining        <= '0;
            ram_write_enable <= 1'b0;
            ram_address      <= '0;
            ram_data_in      <= '0;
            rd_data          <= '0;
            rd_valid         <= 1'b0;
            done             <= 1'b0;
        end else begin
            done             <= 1'b0;
            ram_write_enable <= 1'b0;
            // The address moves only after a write cycle has finished, so
            // it stays stable for the whole cycle the RAM sees the pulse.
            if (ram_write_enable) begin
                ram_address <= ram_address + ADDR_ONE;
            end
            unique case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        ram_address <= cmd_addr;
                        if (cmd_len == '0 || cmd_len > MAX_LEN) begin
                            remaining <= '0;
                            done      <= 1'b1;
                        end else begin
                            remaining <= cmd_len;
                            state     <= cmd_write ? WRITE : READ;
                        end
                    end
                end
                WRITE: begin
                    if (wr_valid) begin
                        ram_data_in      <= wr_data;
                        ram_write_enable <= 1'b1;
                        remaining        <= remaining - LEN_ONE;
                        if (remaining == LEN_ONE) begin
                            state <= IDLE;
                            done  <= 1'b1;
                        end
                    end
                end
                READ: begin
                    if (rd_capture) begin
                        rd_data     <= ram_data_out;
                        rd_valid    <= 1'b1;
                        ram_address <= ram_address + ADDR_ONE;
                        remaining   <= remaining - LEN_ONE;
                        if (remaining == LEN_ONE) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (rd_valid && rd_ready) begin
                        rd_valid <= 1'b0;
                        done     <= 1'b1;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef RAMCTL_CHECKSUM_EN
    // Running sum of every word written to RAM or captured for reading;
    // it is left untouched after done until the next command is taken.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            checksum <= '0;
        end else if (cmd_accept) begin
            checksum <= '0;
        end else if (wr_accept) begin
            checksum <= checksum + wr_data;
        end else if (rd_capture) begin
            checksum <= checksum + ram_data_out;
        end
    end
`endif

endmodule

// File: tb/tb_ram_burst_ctrl.sv
// Directed bench for ram_burst_ctrl with a behavioural 1024x10 RAM that
// captures on the falling edge and reads combinationally.
module tb_ram_burst_ctrl;

    localparam int AW = 10;
    localparam int DW = 10;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [AW:0]   cmd_len = '0;
    logic [DW-1:0] wr_data = '0;
    logic          wr_valid = 1'b0;
    logic          wr_ready;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          rd_ready = 1'b0;
    logic          ram_write_enable;
    logic [AW-1:0] ram_address;
    logic [DW-1:0] ram_data_in;
    logic [DW-1:0] ram_data_out;
    logic          busy;
    logic          done;
`ifdef RAMCTL_CHECKSUM_EN
    logic [DW-1:0] checksum;
`endif

    ram_burst_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk              (clk),
        .reset            (reset),
        .cmd_valid        (cmd_valid),
        .cmd_ready        (cmd_ready),
        .cmd_write        (cmd_write),
        .cmd_addr         (cmd_addr),
        .cmd_len          (cmd_len),
        .wr_data          (wr_data),
        .wr_valid         (wr_valid),
        .wr_ready         (wr_ready),
        .rd_data          (rd_data),
        .rd_valid         (rd_valid),
        .rd_ready         (rd_ready),
        .ram_write_enable (ram_write_enable),
        .ram_address      (ram_address),
        .ram_data_in      (ram_data_in),
        .ram_data_out     (ram_data_out),
        .busy             (busy),
        .done             (done)
`ifdef RAMCTL_CHECKSUM_EN
        ,
        .checksum         (checksum)
`endif
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [0:1023];
    logic [AW-1:0] log_addr [0:63];
    logic [DW-1:0] log_data [0:63];
    int wr_cnt = 0;
    int done_cnt = 0;
    int checks = 0;
    int errors = 0;

    assign ram_data_out = mem[ram_address];

    // RAM model plus write log and done counter, all on the falling edge.
    always @(negedge clk) begin
        if (ram_write_enable) begin
            mem[ram_address] = ram_data_in;
            if (wr_cnt < 64) begin
                log_addr[wr_cnt] = ram_address;
                log_data[wr_cnt] = ram_data_in;
            end
            wr_cnt = wr_cnt + 1;
        end
        if (done) done_cnt = done_cnt + 1;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic w, input logic [AW-1:0] a, input logic [AW:0] l);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_len   = l;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick();
        tick();
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready got %b exp 1", cmd_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (ram_write_enable !== 1'b0) begin errors++; $display("FAIL reset_we got %b exp 0", ram_write_enable); end
        checks++; if (rd_valid !== 1'b0 || done !== 1'b0 || wr_ready !== 1'b0) begin errors++; $display("FAIL reset_flags got rd_valid=%b done=%b wr_ready=%b exp 0", rd_valid, done, wr_ready); end
        checks++; if (ram_address !== '0) begin errors++; $display("FAIL reset_addr got %h exp 000", ram_address); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_write_basic;
        logic [DW-1:0] d [3];
        int s, dc;
        d[0] = 10'h3FF; d[1] = 10'h001; d[2] = 10'h2AA;
        s = wr_cnt; dc = done_cnt;
        send_cmd(1'b1, 10'h005, 11'd3);
        checks++; if (busy !== 1'b1 || wr_ready !== 1'b1 || cmd_ready !== 1'b0) begin errors++; $display("FAIL wr_state got busy=%b wr_ready=%b cmd_ready=%b exp 1 1 0", busy, wr_ready, cmd_ready); end
        for (int i = 0; i < 3; i++) begin
            wr_valid = 1'b1;
            wr_data  = d[i];
            tick();
            checks++; if (ram_write_enable !== 1'b1 || ram_address !== AW'(5 + i) || ram_data_in !== d[i])
                begin errors++; $display("FAIL wr_word%0d got we=%b addr=%h data=%h exp 1 %h %h", i, ram_write_enable, ram_address, ram_data_in, AW'(5 + i), d[i]); end
            checks++; if (done !== (i == 2)) begin errors++; $display("FAIL wr_done%0d got %b exp %b", i, done, (i == 2)); end
        end
        wr_valid = 1'b0;
        tick();
        checks++; if (ram_write_enable !== 1'b0 || done !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL wr_end got we=%b done=%b cmd_ready=%b exp 0 0 1", ram_write_enable, done, cmd_ready); end
        tick();
        checks++; if (wr_cnt - s != 3 || done_cnt - dc != 1) begin errors++; $display("FAIL wr_counts got writes=%0d dones=%0d exp 3 1", wr_cnt - s, done_cnt - dc); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (mem[5 + i] !== d[i]) begin errors++; $display("FAIL wr_mem%0d got %h exp %h", i, mem[5 + i], d[i]); end
        end
    endtask

    task automatic test_read_basic;
        logic [DW-1:0] d [3];
        d[0] = 10'h3FF; d[1] = 10'h001; d[2] = 10'h2AA;
        rd_ready = 1'b1;
        send_cmd(1'b0, 10'h005, 11'd3);
        checks++; if (rd_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL rd_accept got rd_valid=%b busy=%b exp 0 1", rd_valid, busy); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (rd_valid !== 1'b1 || rd_data !== d[i] || wr_ready !== 1'b0)
                begin errors++; $display("FAIL rd_word%0d got valid=%b data=%h wr_ready=%b exp 1 %h 0", i, rd_valid, rd_data, wr_ready, d[i]); end
        end
        tick();
        checks++; if (done !== 1'b1 || rd_valid !== 1'b0) begin errors++; $display("FAIL rd_done got done=%b rd_valid=%b exp 1 0", done, rd_valid); end
`ifdef RAMCTL_CHECKSUM_EN
        checks++; if (checksum !== 10'h2AA) begin errors++; $display("FAIL rd_checksum got %h exp 2aa", checksum); end
`endif
        tick();
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL rd_idle got busy=%b done=%b exp 0 0", busy, done); end
        rd_ready = 1'b0;
    endtask

    task automatic test_write_wrap;
        logic [DW-1:0] d [4];
        int s;
        d[0] = 10'h011; d[1] = 10'h022; d[2] = 10'h033; d[3] = 10'h044;
        s = wr_cnt;
        send_cmd(1'b1, 10'h3FE, 11'd4);
        for (int i = 0; i < 4; i++) begin
            wr_valid = 1'b1;
            wr_data  = d[i];
            tick();
        end
        wr_valid = 1'b0;
        tick();
        tick();
        checks++; if (wr_cnt - s != 4) begin errors++; $display("FAIL wrap_count got %0d exp 4", wr_cnt - s); end
        for (int i = 0; i < 4; i++) begin
            logic [AW-1:0] ea;
            ea = 10'h3FE + AW'(i);
            checks++; if (s + i < 64 && (log_addr[s + i] !== ea || log_data[s + i] !== d[i]))
                begin errors++; $display("FAIL wrap_write%0d got addr=%h data=%h exp %h %h", i, log_addr[s + i], log_data[s + i], ea, d[i]); end
        end
    endtask

    task automatic test_read_stall;
        logic [DW-1:0] e [4];
        logic [DW-1:0] pd;
        logic [AW-1:0] pa;
        logic held, finished;
        int k, dc;
        e[0] = 10'h011; e[1] = 10'h022; e[2] = 10'h033; e[3] = 10'h044;
        k = 0; dc = done_cnt; finished = 1'b0;
        send_cmd(1'b0, 10'h3FE, 11'd4);
        for (int c = 0; c < 40 && !finished; c++) begin
            rd_ready = (c % 4 == 0) || (c % 4 == 3);
            if (rd_valid && rd_ready) begin
                checks++;
                if (k >= 4) begin errors++; $display("FAIL stall_extra got word %0d data=%h exp only 4 words", k, rd_data); end
                else if (rd_data !== e[k]) begin errors++; $display("FAIL stall_word%0d got %h exp %h", k, rd_data, e[k]); end
                k++;
            end
            held = rd_valid && !rd_ready;
            pd = rd_data;
            pa = ram_address;
            tick();
            if (held) begin
                checks++; if (rd_valid !== 1'b1 || rd_data !== pd || ram_address !== pa)
                    begin errors++; $display("FAIL stall_hold got valid=%b data=%h addr=%h exp 1 %h %h", rd_valid, rd_data, ram_address, pd, pa); end
            end
            if (done) finished = 1'b1;
        end
        rd_ready = 1'b0;
        tick();
        checks++; if (!finished || k != 4 || done_cnt - dc != 1) begin errors++; $display("FAIL stall_end got finished=%b words=%0d dones=%0d exp 1 4 1", finished, k, done_cnt - dc); end
    endtask

    task automatic test_write_gap;
        int s, dc;
        s = wr_cnt; dc = done_cnt;
        send_cmd(1'b1, 10'h080, 11'd2);
        wr_valid = 1'b1;
        wr_data  = 10'h155;
        tick();
        wr_valid = 1'b0;
        for (int g = 0; g < 3; g++) begin
            tick();
            checks++; if (ram_write_enable !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL gap_cycle%0d got we=%b busy=%b exp 0 1", g, ram_write_enable, busy); end
        end
        wr_valid = 1'b1;
        wr_data  = 10'h0AA;
        tick();
        checks++; if (ram_write_enable !== 1'b1 || ram_address !== 10'h081 || done !== 1'b1) begin errors++; $display("FAIL gap_last got we=%b addr=%h done=%b exp 1 081 1", ram_write_enable, ram_address, done); end
        wr_valid = 1'b0;
        tick();
        tick();
        checks++; if (wr_cnt - s != 2 || done_cnt - dc != 1) begin errors++; $display("FAIL gap_counts got writes=%0d dones=%0d exp 2 1", wr_cnt - s, done_cnt - dc); end
        checks++; if (mem[10'h080] !== 10'h155 || mem[10'h081] !== 10'h0AA) begin errors++; $display("FAIL gap_mem got %h %h exp 155 0aa", mem[10'h080], mem[10'h081]); end
    endtask

    task automatic test_reset_mid;
        int s, dc;
        s = wr_cnt;
        send_cmd(1'b1, 10'h100, 11'd4);
        wr_valid = 1'b1;
        wr_data  = 10'h101;
        tick();
        wr_data  = 10'h102;
        tick();
        reset = 1'b1;
        #1;
        checks++; if (ram_write_enable !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ctrl got we=%b busy=%b cmd_ready=%b exp 0 0 1", ram_write_enable, busy, cmd_ready); end
        checks++; if (ram_address !== '0 || ram_data_in !== '0 || wr_ready !== 1'b0) begin errors++; $display("FAIL rst_mid_pins got addr=%h data=%h wr_ready=%b exp 000 000 0", ram_address, ram_data_in, wr_ready); end
        wr_data = 10'h103;
        tick();
        tick();
        reset = 1'b0;
        tick();
        tick();
        tick();
        wr_valid = 1'b0;
        checks++; if (wr_cnt - s != 1 || log_addr[s] !== 10'h100 || log_data[s] !== 10'h101)
            begin errors++; $display("FAIL rst_mid_writes got count=%0d addr=%h data=%h exp 1 100 101", wr_cnt - s, log_addr[s], log_data[s]); end
        dc = done_cnt;
        s = wr_cnt;
        send_cmd(1'b1, 10'h200, 11'd0);
        checks++; if (done !== 1'b1 || busy !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL len0 got done=%b busy=%b cmd_ready=%b exp 1 0 1", done, busy, cmd_ready); end
        tick();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL len0_pulse got %b exp 0", done); end
        send_cmd(1'b0, 10'h200, 11'd1025);
        checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL len1025 got done=%b busy=%b exp 1 0", done, busy); end
        tick();
        tick();
        checks++; if (wr_cnt != s || done_cnt - dc != 2) begin errors++; $display("FAIL len0_counts got writes=%0d dones=%0d exp 0 2", wr_cnt - s, done_cnt - dc); end
    endtask

    initial begin
        test_reset();
        test_write_basic();
        test_read_basic();
        test_write_wrap();
        test_read_stall();
        test_write_gap();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
